// File: rtl/tlbmiss_arbiter.sv
// tlbmiss_arbiter: shares the single page-table walker between the ITLB and
// DTLB. One walk runs at a time. DTLB misses win ties, and an ITLB miss that
// keeps losing is forced through after STARVE_LIMIT DTLB grants. The result is
// returned as a one-cycle fill or fault strobe to the TLB that owns the walk.
module tlbmiss_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ITLBMiss,
    input  logic            DTLBMiss,
    input  logic [XLEN-1:0] IVAdr,
    input  logic [XLEN-1:0] DVAdr,
    input  logic            TLBFlush,
    output logic            WalkReq,
    output logic            WalkIsITLB,
    output logic [XLEN-1:0] WalkVAdr,
    output logic            WalkAbort,
    input  logic            WalkDone,
    input  logic            WalkFault,
    input  logic [XLEN-1:0] WalkPTE,
    output logic [XLEN-1:0] FillPTE,
    output logic            ITLBWrite,
    output logic            DTLBWrite,
    output logic            IWalkFault,
    output logic            DWalkFault
);

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        FILL,
        FAULT
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic       idle_hold;   // first IDLE cycle after a walk: no grant allowed
    logic [3:0] starve_cnt;
    logic       grant;
    logic       grant_i;

    // Arbitration: DTLB priority unless the ITLB has been starved long enough.
    always_comb begin
        grant   = (state == IDLE) && !idle_hold && !TLBFlush && (ITLBMiss || DTLBMiss);
        grant_i = ITLBMiss && (!DTLBMiss || (starve_cnt == LIMIT));
    end

    // Next-state and output decode; flush overrides everything in flight.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        WalkReq    = 1'b0;
        WalkAbort  = 1'b0;
        ITLBWrite  = 1'b0;
        DTLBWrite  = 1'b0;
        IWalkFault = 1'b0;
        DWalkFault = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_next = WALK;
            end
            WALK: begin
                if (TLBFlush) begin
                    WalkAbort  = 1'b1;
                    state_next = IDLE;
                end else begin
                    WalkReq = 1'b1;
                    if (WalkDone) state_next = WalkFault ? FAULT : FILL;
                end
            end
            FILL: begin
                if (!TLBFlush) begin
                    ITLBWrite = WalkIsITLB;
                    DTLBWrite = !WalkIsITLB;
                end
                state_next = IDLE;
            end
            FAULT: begin
                if (!TLBFlush) begin
                    IWalkFault = WalkIsITLB;
                    DWalkFault = !WalkIsITLB;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; idle_hold marks the cycle the FSM comes back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from values sampled at the same edge.
        if (reset) begin
            state     <= IDLE;
            idle_hold <= 1'b0;
        end else begin
            state     <= state_next;
            idle_hold <= (state != IDLE);
        end
    end

    // Grant capture and starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WalkIsITLB <= 1'b0;
            WalkVAdr   <= '0;
            starve_cnt <= '0;
        end else if (grant) begin
            WalkIsITLB <= grant_i;
            WalkVAdr   <= grant_i ? IVAdr : DVAdr;
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (ITLBMiss && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Leaf PTE capture on a successful, unflushed walk completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FillPTE <= '0;
        end else if ((state == WALK) && WalkDone && !WalkFault && !TLBFlush) begin
            FillPTE <= WalkPTE;
        end
    end

endmodule

// File: tb/tb_tlbmiss_arbiter.sv
// tb_tlbmiss_arbiter: directed scenarios plus a randomized transaction loop
// checked against a transaction-level model of grant order and strobes.
module tb_tlbmiss_arbiter;

    localparam int XLEN  = 64;
    localparam int LIMIT = 4;

    logic            clk;
    logic            reset;
    logic            ITLBMiss, DTLBMiss;
    logic [XLEN-1:0] IVAdr, DVAdr;
    logic            TLBFlush;
    logic            WalkReq, WalkIsITLB, WalkAbort;
    logic [XLEN-1:0] WalkVAdr;
    logic            WalkDone, WalkFault;
    logic [XLEN-1:0] WalkPTE, FillPTE;
    logic            ITLBWrite, DTLBWrite, IWalkFault, DWalkFault;
    logic [3:0]      strb;

    int total = 0;
    int bad   = 0;

    assign strb = {ITLBWrite, DTLBWrite, IWalkFault, DWalkFault};

    tlbmiss_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ITLBMiss(ITLBMiss), .DTLBMiss(DTLBMiss),
        .IVAdr(IVAdr), .DVAdr(DVAdr), .TLBFlush(TLBFlush),
        .WalkReq(WalkReq), .WalkIsITLB(WalkIsITLB), .WalkVAdr(WalkVAdr),
        .WalkAbort(WalkAbort), .WalkDone(WalkDone), .WalkFault(WalkFault),
        .WalkPTE(WalkPTE), .FillPTE(FillPTE),
        .ITLBWrite(ITLBWrite), .DTLBWrite(DTLBWrite),
        .IWalkFault(IWalkFault), .DWalkFault(DWalkFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ITLBMiss = 1'b0; DTLBMiss = 1'b0;
        IVAdr    = '0;   DVAdr    = '0;
        TLBFlush = 1'b0; WalkDone = 1'b0; WalkFault = 1'b0; WalkPTE = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Ticks until WalkReq is seen or the cycle budget runs out.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (WalkReq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Completes the current walk; leaves the bench in the FILL/FAULT cycle.
    task automatic complete_walk(input bit fault, input logic [XLEN-1:0] pte);
        WalkDone = 1'b1; WalkFault = fault; WalkPTE = pte;
        tick();
        WalkDone = 1'b0; WalkFault = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", WalkReq); end
        total++; if (WalkAbort !== 1'b0) begin bad++; $display("FAIL reset_abort: got %b want 0", WalkAbort); end
        total++; if (strb !== 4'b0000) begin bad++; $display("FAIL reset_strb: got %b want 0000", strb); end
        total++; if (WalkIsITLB !== 1'b0) begin bad++; $display("FAIL reset_owner: got %b want 0", WalkIsITLB); end
        total++; if (WalkVAdr !== '0) begin bad++; $display("FAIL reset_vadr: got %h want 0", WalkVAdr); end
        total++; if (FillPTE !== '0) begin bad++; $display("FAIL reset_pte: got %h want 0", FillPTE); end
    endtask

    task automatic test_itlb_fill();
        bit req_ok;
        do_reset();
        ITLBMiss = 1'b1; IVAdr = 64'h8000_1000;
        #1;
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL itlb_req_c0: got %b want 0", WalkReq); end
        req_ok = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (WalkReq !== 1'b1) req_ok = 1'b0;
            if (c == 1) begin
                total++; if (WalkIsITLB !== 1'b1) begin bad++; $display("FAIL itlb_owner: got %b want 1", WalkIsITLB); end
                total++; if (WalkVAdr !== 64'h8000_1000) begin bad++; $display("FAIL itlb_vadr: got %h want 80001000", WalkVAdr); end
            end
        end
        total++; if (!req_ok) begin bad++; $display("FAIL itlb_req_window: got dropout want high cycles 1-6"); end
        complete_walk(1'b0, 64'h2000_04CF);
        total++; if (strb !== 4'b1000) begin bad++; $display("FAIL itlb_write: got %b want 1000", strb); end
        total++; if (FillPTE !== 64'h2000_04CF) begin bad++; $display("FAIL itlb_pte: got %h want 200004cf", FillPTE); end
        tick();
        ITLBMiss = 1'b0;
        #1;
        total++; if (strb !== 4'b0000) begin bad++; $display("FAIL itlb_single_write: got %b want 0000", strb); end
        tick();
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL itlb_idle: got %b want 0", WalkReq); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ITLBMiss = 1'b1; IVAdr = 64'h0000_1111_0000;
        DTLBMiss = 1'b1; DVAdr = 64'h0000_2222_0000;
        tick();
        total++; if (WalkIsITLB !== 1'b0) begin bad++; $display("FAIL simul_first_owner: got %b want 0", WalkIsITLB); end
        total++; if (WalkVAdr !== 64'h0000_2222_0000) begin bad++; $display("FAIL simul_first_vadr: got %h want 222220000", WalkVAdr); end
        complete_walk(1'b0, 64'hAB);
        total++; if (strb !== 4'b0100) begin bad++; $display("FAIL simul_dwrite: got %b want 0100", strb); end
        tick();
        DTLBMiss = 1'b0;
        #1;
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL simul_hold: got %b want 0", WalkReq); end
        tick();
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL simul_arb_cycle: got %b want 0", WalkReq); end
        tick();
        total++; if (WalkReq !== 1'b1) begin bad++; $display("FAIL simul_second_req: got %b want 1", WalkReq); end
        total++; if (WalkIsITLB !== 1'b1) begin bad++; $display("FAIL simul_second_owner: got %b want 1", WalkIsITLB); end
        total++; if (WalkVAdr !== 64'h0000_1111_0000) begin bad++; $display("FAIL simul_second_vadr: got %h want 111110000", WalkVAdr); end
        complete_walk(1'b0, 64'hCD);
        total++; if (strb !== 4'b1000) begin bad++; $display("FAIL simul_iwrite: got %b want 1000", strb); end
        tick();
        ITLBMiss = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        bit ok;
        do_reset();
        ITLBMiss = 1'b1; IVAdr = 64'h4000;
        for (int k = 0; k < 5; k++) begin
            DTLBMiss = 1'b1; DVAdr = 64'h9000 + 64'(k);
            wait_grant(ok);
            total++; if (!ok) begin bad++; $display("FAIL starve_grant%0d: got timeout want grant", k); end
            total++; if (WalkIsITLB !== ((k == 4) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL starve_order%0d: got %b want %b", k, WalkIsITLB, (k == 4));
            end
            complete_walk(1'b0, 64'(k));
            tick();
            if (WalkIsITLB) ITLBMiss = 1'b0;
            else            DTLBMiss = 1'b0;
        end
        // DTLB is still waiting; a fresh ITLB miss must now lose (counter cleared).
        ITLBMiss = 1'b1;
        wait_grant(ok);
        total++; if (!ok || WalkIsITLB !== 1'b0) begin bad++; $display("FAIL starve_cleared: got ok=%b owner=%b want ok=1 owner=0", ok, WalkIsITLB); end
        complete_walk(1'b0, 64'h0);
        tick();
        DTLBMiss = 1'b0;
        wait_grant(ok);
        complete_walk(1'b0, 64'h0);
        tick();
        ITLBMiss = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        do_reset();
        DTLBMiss = 1'b1; DVAdr = 64'h7777_0000;
        tick();
        total++; if (WalkIsITLB !== 1'b0) begin bad++; $display("FAIL fault_owner: got %b want 0", WalkIsITLB); end
        complete_walk(1'b1, 64'hDEAD);
        total++; if (strb !== 4'b0001) begin bad++; $display("FAIL fault_pulse: got %b want 0001", strb); end
        tick();
        DTLBMiss = 1'b0;
        #1;
        total++; if (strb !== 4'b0000) begin bad++; $display("FAIL fault_single: got %b want 0000", strb); end
        tick();
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL fault_idle: got %b want 0", WalkReq); end
    endtask

    task automatic test_flush_done();
        do_reset();
        ITLBMiss = 1'b1; IVAdr = 64'h5000;
        tick();
        tick();
        WalkDone = 1'b1; WalkPTE = 64'h1234; TLBFlush = 1'b1;
        #1;
        total++; if (WalkAbort !== 1'b1) begin bad++; $display("FAIL flush_abort: got %b want 1", WalkAbort); end
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL flush_req_drop: got %b want 0", WalkReq); end
        tick();
        WalkDone = 1'b0; TLBFlush = 1'b0;
        #1;
        total++; if (strb !== 4'b0000 || WalkAbort !== 1'b0) begin bad++; $display("FAIL flush_no_strobe: got strb=%b abort=%b want 0000/0", strb, WalkAbort); end
        tick();
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL flush_arb_cycle: got %b want 0", WalkReq); end
        tick();
        total++; if (WalkReq !== 1'b1 || WalkIsITLB !== 1'b1) begin bad++; $display("FAIL flush_regrant: got req=%b owner=%b want 1/1", WalkReq, WalkIsITLB); end
        complete_walk(1'b0, 64'h0);
        tick();
        ITLBMiss = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        ITLBMiss = 1'b1; IVAdr = 64'h6000;
        tick();
        complete_walk(1'b0, 64'hFACE);
        tick();
        ITLBMiss = 1'b0;
        DTLBMiss = 1'b1; DVAdr = 64'h6100;
        tick();
        tick();
        total++; if (WalkReq !== 1'b1) begin bad++; $display("FAIL areset_pre_req: got %b want 1", WalkReq); end
        #1 reset = 1'b1;
        #1;
        total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL areset_req: got %b want 0", WalkReq); end
        total++; if (WalkAbort !== 1'b0) begin bad++; $display("FAIL areset_abort: got %b want 0", WalkAbort); end
        total++; if (strb !== 4'b0000 || WalkIsITLB !== 1'b0) begin bad++; $display("FAIL areset_strb: got strb=%b owner=%b want 0000/0", strb, WalkIsITLB); end
        total++; if (WalkVAdr !== '0 || FillPTE !== '0) begin bad++; $display("FAIL areset_regs: got vadr=%h pte=%h want 0/0", WalkVAdr, FillPTE); end
        DTLBMiss = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Randomized transactions against a model of grant order and strobes.
    task automatic test_random();
        bit              i_pend, d_pend, exp_i, flush_fill, req_ok;
        int              cnt, act, lat;
        logic [XLEN-1:0] exp_addr, pte;
        logic [3:0]      exp_strb;
        do_reset();
        cnt = 0; i_pend = 1'b0; d_pend = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (!i_pend && ($urandom % 2 == 0)) begin i_pend = 1'b1; IVAdr = {$urandom, $urandom}; end
            if (!d_pend && ($urandom % 2 == 0)) begin d_pend = 1'b1; DVAdr = {$urandom, $urandom}; end
            if (!i_pend && !d_pend) begin d_pend = 1'b1; DVAdr = {$urandom, $urandom}; end
            ITLBMiss = i_pend; DTLBMiss = d_pend;
            if ($urandom % 6 == 0) begin
                TLBFlush = 1'b1;
                tick();
                TLBFlush = 1'b0;
                #1;
                total++; if (WalkReq !== 1'b0) begin bad++; $display("FAIL rnd_idle_flush%0d: got %b want 0", n, WalkReq); end
            end
            exp_i    = i_pend && (!d_pend || cnt == LIMIT);
            exp_addr = exp_i ? IVAdr : DVAdr;
            if (exp_i)       cnt = 0;
            else if (i_pend) cnt = (cnt + 1 > LIMIT) ? LIMIT : cnt + 1;
            tick();
            total++; if (WalkReq !== 1'b1 || WalkIsITLB !== exp_i) begin
                bad++; $display("FAIL rnd_grant%0d: got req=%b owner=%b want 1/%b", n, WalkReq, WalkIsITLB, exp_i);
            end
            total++; if (WalkVAdr !== exp_addr) begin bad++; $display("FAIL rnd_vadr%0d: got %h want %h", n, WalkVAdr, exp_addr); end
            lat = $urandom_range(0, 3);
            req_ok = 1'b1;
            for (int j = 0; j < lat; j++) begin
                tick();
                if (WalkReq !== 1'b1) req_ok = 1'b0;
            end
            total++; if (!req_ok) begin bad++; $display("FAIL rnd_req_hold%0d: got dropout want 1", n); end
            act = $urandom_range(0, 2);
            pte = {$urandom, $urandom};
            WalkPTE   = pte;
            WalkDone  = (act != 2) || ($urandom % 2 == 0);
            WalkFault = (act == 1) || ((act == 2) && ($urandom % 2 == 0));
            TLBFlush  = (act == 2);
            #1;
            total++; if (WalkAbort !== (act == 2)) begin bad++; $display("FAIL rnd_abort%0d: got %b want %b", n, WalkAbort, (act == 2)); end
            tick();
            WalkDone = 1'b0; WalkFault = 1'b0; TLBFlush = 1'b0;
            if (act != 2) begin
                flush_fill = ($urandom % 5 == 0);
                TLBFlush = flush_fill;
                #1;
                if (flush_fill)     exp_strb = 4'b0000;
                else if (act == 0)  exp_strb = exp_i ? 4'b1000 : 4'b0100;
                else                exp_strb = exp_i ? 4'b0010 : 4'b0001;
                total++; if (strb !== exp_strb) begin bad++; $display("FAIL rnd_strobe%0d: got %b want %b", n, strb, exp_strb); end
                if (act == 0) begin
                    total++; if (FillPTE !== pte) begin bad++; $display("FAIL rnd_pte%0d: got %h want %h", n, FillPTE, pte); end
                end
                if (!flush_fill) begin
                    if (exp_i) i_pend = 1'b0;
                    else       d_pend = 1'b0;
                end
                tick();
                TLBFlush = 1'b0;
            end
            ITLBMiss = i_pend; DTLBMiss = d_pend;
            #1;
            total++; if (WalkReq !== 1'b0 || strb !== 4'b0000) begin
                bad++; $display("FAIL rnd_return%0d: got req=%b strb=%b want 0/0000", n, WalkReq, strb);
            end
            tick();
        end
        ITLBMiss = 1'b0; DTLBMiss = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_itlb_fill();
        test_simultaneous();
        test_starvation();
        test_fault();
        test_flush_done();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
